// File: rtl/simple_dram_arb.sv
// simple_dram_arb: N-port request arbiter onto a single UMI channel.
//   Each client port has a request FIFO, a response FIFO and a read-credit
//   counter. A round-robin arbiter drives umi_req_out. In-order read data is
//   steered back to the issuing port through a port-ID tag FIFO.
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   umi_req_out / umi_req_grant_in  arbitrated request and its grant
//   umi_write_out / _ready_in       write data (valid in the grant cycle only)
//   umi_read_in / umi_read_grant_out in-order read data, always accepted
//   mem_req_in / mem_req_ready_out  per-port requests
//   mem_resp_out / mem_resp_ready_in per-port read responses
//   err_orphan_out                  sticky: read data with no tag outstanding

package simple_dram_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 16;

  typedef struct packed {
    logic              valid;
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

  typedef struct packed {
    logic              valid;
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } umi_req_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } umi_wdata_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } umi_rdata_t;

  // Request FIFO entry (valid is implied by occupancy).
  typedef struct packed {
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_ent_t;
endpackage

// Synchronous FIFO, 2**LOG_D entries (LOG_D >= 1), show-ahead read.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module simple_dram_arb_fifo #(
  parameter int W     = 8,
  parameter int LOG_D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int D = 1 << LOG_D;
  localparam logic [LOG_D:0] FULL_CNT = (LOG_D+1)'(D);

  logic [W-1:0]   mem_q [D];
  logic [LOG_D:0] wptr_q, rptr_q;
  logic           do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q - rptr_q) == FULL_CNT);
  assign dout_o  = mem_q[rptr_q[LOG_D-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[LOG_D-1:0]] <= din_i;
  end
endmodule

module simple_dram_arb
  import simple_dram_arb_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int REQ_LOG_DEPTH = 5,
  parameter int RESP_CREDITS  = 64,  // power of 2, >= 2
  parameter int TAG_LOG_DEPTH = 8,
  parameter int BURST_BYTES   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  output umi_req_t                umi_req_out,
  input  logic                    umi_req_grant_in,
  output umi_wdata_t              umi_write_out,
  input  logic                    umi_write_ready_in,
  input  umi_rdata_t              umi_read_in,
  output logic                    umi_read_grant_out,
  input  mem_req_t  [N_PORTS-1:0] mem_req_in,
  output logic      [N_PORTS-1:0] mem_req_ready_out,
  output mem_resp_t [N_PORTS-1:0] mem_resp_out,
  input  logic      [N_PORTS-1:0] mem_resp_ready_in,
  output logic                    err_orphan_out
);
  localparam int PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW   = $clog2(RESP_CREDITS + 1);
  localparam int RLOG = $clog2(RESP_CREDITS);
  localparam logic [CW-1:0] CRED_MAX = CW'(RESP_CREDITS);

  logic                       blk, rst_d1_q;
  logic                       lock_q, lock_d;
  logic [PW-1:0]              lock_sel_q, lock_sel_d, rr_q, rr_d, pick, sel;
  logic                       any_elig, req_vld, grant, rd_acc;
  logic                       orphan_q, orphan_d;
  req_ent_t [N_PORTS-1:0]     head;
  logic [N_PORTS-1:0]         rq_empty, rq_full, rq_push, rq_pop, elig;
  logic [N_PORTS-1:0]         rs_empty, rs_full, rs_push, rs_pop, cr_inc;
  logic [N_PORTS-1:0][DATA_W-1:0] rs_dout;
  logic [CW-1:0]              cred_q [N_PORTS];
  logic                       tag_push, tag_pop, tag_empty, tag_full;
  logic [PW-1:0]              tag_dout;
  logic                       unused_rs_full;

  // Outputs stay quiet during reset and for one cycle after it, so that
  // anything sampled around the reset edge is not mistaken for live traffic.
  assign blk = rst | rst_d1_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    simple_dram_arb_fifo #(.W($bits(req_ent_t)), .LOG_D(REQ_LOG_DEPTH)) u_reqq (
      .clk(clk), .rst(rst),
      .push_i(rq_push[p]),
      .din_i({mem_req_in[p].isWrite, mem_req_in[p].addr, mem_req_in[p].data}),
      .pop_i(rq_pop[p]), .dout_o(head[p]),
      .empty_o(rq_empty[p]), .full_o(rq_full[p])
    );

    assign mem_req_ready_out[p] = !rq_full[p] && !blk;
    assign rq_push[p] = mem_req_in[p].valid && mem_req_ready_out[p];
    assign elig[p]    = !rq_empty[p] && !blk &&
                        (head[p].isWrite ? umi_write_ready_in
                                         : ((cred_q[p] < CRED_MAX) && !tag_full));
    assign rq_pop[p]  = grant && (sel == PW'(p));
    assign cr_inc[p]  = tag_push && (sel == PW'(p));
    assign rs_push[p] = tag_pop && (tag_dout == PW'(p));
    assign rs_pop[p]  = mem_resp_ready_in[p] && !rs_empty[p] && !blk;

    // Credits bound outstanding reads, so a push never finds this full.
    simple_dram_arb_fifo #(.W(DATA_W), .LOG_D(RLOG)) u_respq (
      .clk(clk), .rst(rst),
      .push_i(rs_push[p]), .din_i(umi_read_in.data),
      .pop_i(rs_pop[p]), .dout_o(rs_dout[p]),
      .empty_o(rs_empty[p]), .full_o(rs_full[p])
    );

    assign mem_resp_out[p] = '{valid: !rs_empty[p] && !blk, data: rs_dout[p]};

    always_ff @(posedge clk) begin
      if (rst)                          cred_q[p] <= '0;
      else if (cr_inc[p] && !rs_pop[p]) cred_q[p] <= cred_q[p] + CW'(1);
      else if (!cr_inc[p] && rs_pop[p]) cred_q[p] <= cred_q[p] - CW'(1);
    end
  end

  assign unused_rs_full = ^rs_full;

  // Round-robin: first eligible port at or after rr_q, wrapping.
  always_comb begin
    int idx;
    pick     = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rr_q) + i) % N_PORTS;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        pick     = PW'(idx);
      end
    end
  end

  // A locked port keeps valid high even if its eligibility drops, so the
  // request presented to UMI never changes under a pending grant.
  assign sel      = lock_q ? lock_sel_q : pick;
  assign req_vld  = !blk && (lock_q || any_elig);
  assign grant    = req_vld && umi_req_grant_in;
  assign tag_push = grant && !head[sel].isWrite;

  assign umi_req_out   = '{valid: req_vld, isWrite: head[sel].isWrite,
                           addr: head[sel].addr, size: SIZE_W'(BURST_BYTES)};
  assign umi_write_out = '{valid: grant && head[sel].isWrite, data: head[sel].data};

  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    rr_d       = rr_q;
    if (grant) begin
      lock_d = 1'b0;
      rr_d   = PW'((int'(sel) + 1) % N_PORTS);
    end else if (req_vld) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end
  end

  simple_dram_arb_fifo #(.W(PW), .LOG_D(TAG_LOG_DEPTH)) u_tagq (
    .clk(clk), .rst(rst),
    .push_i(tag_push), .din_i(sel),
    .pop_i(tag_pop), .dout_o(tag_dout),
    .empty_o(tag_empty), .full_o(tag_full)
  );

  assign rd_acc             = umi_read_in.valid && !blk;
  assign umi_read_grant_out = rd_acc;
  assign tag_pop            = rd_acc && !tag_empty;
  assign orphan_d           = orphan_q | (rd_acc && tag_empty);
  assign err_orphan_out     = orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_d1_q   <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      rr_q       <= '0;
      orphan_q   <= 1'b0;
    end else begin
      rst_d1_q   <= 1'b0;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      rr_q       <= rr_d;
      orphan_q   <= orphan_d;
    end
  end
endmodule

// File: tb/tb_simple_dram_arb.sv
module tb_simple_dram_arb;
  import simple_dram_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  umi_req_t         ureq;
  logic             ugnt = 1'b0;
  umi_wdata_t       uwr;
  logic             wrdy = 1'b0;
  umi_rdata_t       urd = '0;
  logic             urd_gnt;
  mem_req_t  [3:0]  mreq = '0;
  logic      [3:0]  mrdy;
  mem_resp_t [3:0]  mresp;
  logic      [3:0]  rrdy = '0;
  logic             orph;
  logic      [3:0]  rv;

  int errs = 0;
  int checks = 0;

  simple_dram_arb dut (
    .clk(clk), .rst(rst),
    .umi_req_out(ureq), .umi_req_grant_in(ugnt),
    .umi_write_out(uwr), .umi_write_ready_in(wrdy),
    .umi_read_in(urd), .umi_read_grant_out(urd_gnt),
    .mem_req_in(mreq), .mem_req_ready_out(mrdy),
    .mem_resp_out(mresp), .mem_resp_ready_in(rrdy),
    .err_orphan_out(orph)
  );

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < 4; i++) rv[i] = mresp[i].valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; ugnt = 1'b0; wrdy = 1'b0; urd = '0; mreq = '0; rrdy = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int issued, pushed;

    // ---- reset state, read return ignored during and right after reset
    urd = '{valid: 1'b1, data: 64'h55};
    tick; tick;
    chk("rst_req_vld", ureq.valid, 0);
    chk("rst_rd_gnt", urd_gnt, 0);
    chk("rst_orphan", orph, 0);
    chk("rst_resp_vld", rv, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rd_gnt", urd_gnt, 0);
    urd.valid = 1'b0;
    tick;
    chk("post_rst_ready", mrdy, 4'hF);
    chk("post_rst_orphan", orph, 0);

    // ---- 1: single read on port 0
    mreq[0] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h1000, data: 64'h0};
    tick;
    mreq[0].valid = 1'b0;
    #1;
    chk("t1_req_vld", ureq.valid, 1);
    chk("t1_iswr", ureq.isWrite, 0);
    chk("t1_addr", ureq.addr, 32'h1000);
    chk("t1_size", ureq.size, 64);
    ugnt = 1'b1;
    tick;
    ugnt = 1'b0;
    #1;
    chk("t1_req_idle", ureq.valid, 0);
    urd = '{valid: 1'b1, data: 64'hD0D0_0000_0000_0001};
    #1;
    chk("t1_rd_gnt", urd_gnt, 1);
    tick;
    urd.valid = 1'b0;
    #1;
    chk("t1_resp_vld", rv, 4'b0001);
    chk("t1_resp_data", mresp[0].data, 64'hD0D0_0000_0000_0001);
    rrdy[0] = 1'b1;
    tick;
    rrdy[0] = 1'b0;
    #1;
    chk("t1_resp_popped", rv, 0);
    chk("t1_orphan", orph, 0);

    // ---- 2: four ports, grant tied high -> order 0,1,2,3
    reset_dut();
    for (int p = 0; p < 4; p++)
      mreq[p] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h2000 + 32'(p) * 32'h100, data: 64'h0};
    tick;
    mreq = '0;
    ugnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_vld%0d", k), ureq.valid, 1);
      chk($sformatf("t2_addr%0d", k), ureq.addr, 32'h2000 + 32'(k) * 32'h100);
      tick;
    end
    ugnt = 1'b0;
    #1;
    chk("t2_idle", ureq.valid, 0);
    for (int k = 0; k < 4; k++) begin
      urd = '{valid: 1'b1, data: 64'hD0 + 64'(k)};
      tick;
    end
    urd.valid = 1'b0;
    #1;
    chk("t2_resp_vld", rv, 4'hF);
    for (int p = 0; p < 4; p++)
      chk($sformatf("t2_data%0d", p), mresp[p].data, 64'hD0 + 64'(p));
    rrdy = 4'hF;
    tick;
    rrdy = '0;

    // ---- 3: credit exhaustion on port 1
    reset_dut();
    issued = 0;
    pushed = 0;
    mreq[1] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h3000, data: 64'h0};
    ugnt = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ureq.valid && ureq.addr == 32'h3000) issued++;
      if (mreq[1].valid && mrdy[1]) pushed++;
      tick;
      if (pushed == 65) mreq[1].valid = 1'b0;
    end
    chk("t3_issued", 64'(issued), 64);
    chk("t3_blocked", ureq.valid, 0);
    mreq[2] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h4000, data: 64'h0};
    tick;
    mreq[2].valid = 1'b0;
    #1;
    chk("t3_p2_vld", ureq.valid, 1);
    chk("t3_p2_addr", ureq.addr, 32'h4000);
    tick;
    chk("t3_still_blocked", ureq.valid, 0);
    urd = '{valid: 1'b1, data: 64'hAA};
    tick;
    urd.valid = 1'b0;
    #1;
    chk("t3_resp1_data", mresp[1].data, 64'hAA);
    chk("t3_resp1_vld", rv, 4'b0010);
    rrdy[1] = 1'b1;
    tick;
    rrdy[1] = 1'b0;
    #1;
    chk("t3_65th_vld", ureq.valid, 1);
    chk("t3_65th_addr", ureq.addr, 32'h3000);
    tick;
    ugnt = 1'b0;

    // ---- 4: write gating and lock
    reset_dut();
    mreq[0] = '{valid: 1'b1, isWrite: 1'b1, addr: 32'h5000, data: 64'h1234};
    tick;
    mreq[0].valid = 1'b0;
    #1;
    chk("t4_not_sel", ureq.valid, 0);
    tick;
    wrdy = 1'b1;
    #1;
    chk("t4_a_vld", ureq.valid, 1);
    chk("t4_a_iswr", ureq.isWrite, 1);
    chk("t4_a_wvld", uwr.valid, 0);
    tick;
    wrdy = 1'b0;
    mreq[1] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h6000, data: 64'h0};
    #1;
    chk("t4_b_vld", ureq.valid, 1);
    tick;
    mreq[1].valid = 1'b0;
    #1;
    chk("t4_c_vld", ureq.valid, 1);
    chk("t4_c_addr", ureq.addr, 32'h5000);
    tick;
    wrdy = 1'b1;
    ugnt = 1'b1;
    #1;
    chk("t4_d_wvld", uwr.valid, 1);
    chk("t4_d_wdata", uwr.data, 64'h1234);
    tick;
    ugnt = 1'b0;
    #1;
    chk("t4_e_wvld", uwr.valid, 0);
    chk("t4_e_addr", ureq.addr, 32'h6000);

    // ---- 5: grant, return and pop on port 2 in one cycle
    reset_dut();
    ugnt = 1'b1;
    mreq[2] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h7000, data: 64'h0};
    tick; tick;
    mreq[2].valid = 1'b0;
    tick;
    ugnt = 1'b0;
    urd = '{valid: 1'b1, data: 64'hD1};
    tick;
    urd.valid = 1'b0;
    mreq[2].valid = 1'b1;
    tick;
    mreq[2].valid = 1'b0;
    ugnt = 1'b1;
    urd = '{valid: 1'b1, data: 64'hD2};
    rrdy[2] = 1'b1;
    #1;
    chk("t5_req_vld", ureq.valid, 1);
    chk("t5_pop_data", mresp[2].data, 64'hD1);
    tick;
    ugnt = 1'b0;
    urd.valid = 1'b0;
    rrdy[2] = 1'b0;
    #1;
    chk("t5_cred", 64'(dut.cred_q[2]), 2);
    chk("t5_data2", mresp[2].data, 64'hD2);
    chk("t5_vld2", rv, 4'b0100);
    rrdy[2] = 1'b1;
    urd = '{valid: 1'b1, data: 64'hD3};
    tick;
    rrdy[2] = 1'b0;
    urd.valid = 1'b0;
    #1;
    chk("t5_data3", mresp[2].data, 64'hD3);
    chk("t5_cred_after", 64'(dut.cred_q[2]), 1);

    // ---- 6: orphan read data, reset mid-burst
    reset_dut();
    urd = '{valid: 1'b1, data: 64'h99};
    #1;
    chk("t6_orph_gnt", urd_gnt, 1);
    tick;
    urd.valid = 1'b0;
    #1;
    chk("t6_orph_set", orph, 1);
    chk("t6_orph_drop", rv, 0);
    tick; tick;
    chk("t6_orph_sticky", orph, 1);
    ugnt = 1'b1;
    mreq[0] = '{valid: 1'b1, isWrite: 1'b0, addr: 32'h8000, data: 64'h0};
    tick; tick;
    mreq[0].valid = 1'b0;
    tick;
    ugnt = 1'b0;
    urd = '{valid: 1'b1, data: 64'hE1};
    tick;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", ureq.valid, 0);
    chk("t6_rst_rdgnt", urd_gnt, 0);
    chk("t6_rst_resp", rv, 0);
    tick;
    chk("t6_rst_orph", orph, 0);
    chk("t6_rst_ready", mrdy, 0);
    rst = 1'b0;
    tick;
    chk("t6_late_gnt", urd_gnt, 1);
    tick;
    urd.valid = 1'b0;
    #1;
    chk("t6_late_orph", orph, 1);
    chk("t6_late_resp", rv, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
